ct_f_spsram_bwe: RTL and testbench

CT_F_SPSRAM_BWE -- requirements
Module: ct_f_spsram_bwe

---
 rtl/ct_f_sram_pkg.sv | 17 +
 rtl/fpga_ram.sv | 27 ++
 rtl/ct_f_spsram_bwe.sv | 147 ++++++++++++++
 tb/tb_ct_f_spsram_bwe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ct_f_sram_pkg.sv
// Shared definitions for the single-port byte/bit-write-enable SRAM family.
//   state_t   : controller states (INIT clears the array, IDLE accepts
//               accesses, RMW completes a partial write)
//   seg_count : number of storage slices needed to cover a word
package ct_f_sram_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RMW  = 2'd2
  } state_t;

  function automatic int seg_count(input int data_w, input int seg_w);
    return (data_w + seg_w - 1) / seg_w;
  endfunction

endpackage

// File: rtl/fpga_ram.sv
// Single storage-primitive slice: synchronous write, asynchronous read.
// Ports:
//   clk  : write clock
//   we   : write strobe, active-high
//   addr : word address (read and write share it)
//   din  : write data
//   dout : contents of mem[addr], combinational
module fpga_ram #(
  parameter int width      = 29,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [width-1:0]      din,
  output logic [width-1:0]      dout
);

  logic [width-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  assign dout = mem[addr];

endmodule

// File: rtl/ct_f_spsram_bwe.sv
// Single-port SRAM with global and per-bit active-low write enables.
// Full writes complete in one cycle; partial writes take an extra
// read-modify-write cycle during which BUSY is high. An optional clear
// sequence writes INIT_VALUE to every word after reset.
// Ports:
//   CLK  : clock, all state on posedge
//   RST  : synchronous active-high reset
//   CEN  : chip enable, active-low
//   A    : word address
//   GWEN : global write enable, active-low
//   WEN  : per-bit write enable, active-low
//   D    : write data
//   Q    : registered read data
//   BUSY : high while an access cannot be accepted
module ct_f_spsram_bwe
  import ct_f_sram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 59,
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    SEG_WIDTH  = 29,
  parameter int                    INIT_EN    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CEN,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  BUSY
);

  localparam int NSEG = seg_count(DATA_WIDTH, SEG_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  // Bits with WEN=0 take the new data, bits with WEN=1 keep the old word.
  function automatic logic [DATA_WIDTH-1:0] merge_bits(
    input logic [DATA_WIDTH-1:0] d,
    input logic [DATA_WIDTH-1:0] wen,
    input logic [DATA_WIDTH-1:0] old
  );
    return (d & ~wen) | (old & wen);
  endfunction

  state_t                  state;
  state_t                  state_nx;
  logic [ADDR_WIDTH-1:0]   init_cnt;

  logic                    accept_p0;
  logic                    is_full_p0;
  logic                    is_part_p0;

  logic [ADDR_WIDTH-1:0]   req_a_p1;
  logic                    req_gwen_p1;
  logic [DATA_WIDTH-1:0]   req_wen_p1;
  logic [DATA_WIDTH-1:0]   req_d_p1;

  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic [DATA_WIDTH-1:0]   ram_rdata;
  logic [DATA_WIDTH-1:0]   merged_p1;

  // Stage p0: request decode at the acceptance cycle
  assign accept_p0  = !CEN && !BUSY && (state == ST_IDLE);
  assign is_full_p0 = !GWEN && (WEN == '0);
  assign is_part_p0 = !GWEN && !(&WEN) && (|WEN);

  // Stage p1: merge uses the latched request and the word currently at the
  // latched address (the array port is steered there during RMW).
  assign merged_p1 = merge_bits(req_d_p1, req_wen_p1, ram_rdata);

  always_comb begin
    state_nx  = state;
    ram_we    = 1'b0;
    ram_addr  = A;
    ram_wdata = D;
    case (state)
      ST_INIT: begin
        ram_we    = 1'b1;
        ram_addr  = init_cnt;
        ram_wdata = INIT_VALUE;
        if (init_cnt == LAST_ADDR) state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept_p0) begin
          if (is_full_p0)      ram_we   = 1'b1;
          else if (is_part_p0) state_nx = ST_RMW;
        end
      end
      ST_RMW: begin
        ram_we    = !req_gwen_p1;
        ram_addr  = req_a_p1;
        ram_wdata = merged_p1;
        state_nx  = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    // Reset drops any write in flight, including a pending RMW.
    if (RST) ram_we = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= (INIT_EN != 0) ? ST_INIT : ST_IDLE;
      BUSY        <= (INIT_EN != 0);
      init_cnt    <= '0;
      req_a_p1    <= '0;
      req_gwen_p1 <= 1'b0;
      req_wen_p1  <= '0;
      req_d_p1    <= '0;
      Q           <= '0;
    end else begin
      state <= state_nx;
      BUSY  <= (state_nx != ST_IDLE);
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
      if (accept_p0) begin
        req_a_p1    <= A;
        req_gwen_p1 <= GWEN;
        req_wen_p1  <= WEN;
        req_d_p1    <= D;
      end
      // Q only moves when an access completes; partial writes complete in RMW.
      if (state == ST_RMW)                Q <= merged_p1;
      else if (accept_p0 && !is_part_p0)  Q <= is_full_p0 ? D : ram_rdata;
    end
  end

  // Storage slices share address and strobe; the last one takes the remainder.
  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    localparam int LO = g * SEG_WIDTH;
    localparam int W  = (g == NSEG - 1) ? (DATA_WIDTH - LO) : SEG_WIDTH;
    fpga_ram #(
      .width      (W),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
      .clk  (CLK),
      .we   (ram_we),
      .addr (ram_addr),
      .din  (ram_wdata[LO +: W]),
      .dout (ram_rdata[LO +: W])
    );
  end

endmodule

// File: tb/tb_ct_f_spsram_bwe.sv
// Self-checking bench: two instances (59-bit with clear, 64-bit without),
// directed scenarios plus random traffic, checked every cycle against a
// word-level model of the memory.
module tb_ct_f_spsram_bwe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: defaults (59 bits, INIT_EN=1)
  logic        rst_a, cen_a, gwen_a, busy_a;
  logic [8:0]  a_a;
  logic [58:0] wen_a, d_a, q_a;
  // instance B: 64 bits, INIT_EN=0
  logic        rst_b, cen_b, gwen_b, busy_b;
  logic [8:0]  a_b;
  logic [63:0] wen_b, d_b, q_b;

  ct_f_spsram_bwe dut_a (
    .CLK(clk), .RST(rst_a), .CEN(cen_a), .A(a_a), .GWEN(gwen_a),
    .WEN(wen_a), .D(d_a), .Q(q_a), .BUSY(busy_a)
  );

  ct_f_spsram_bwe #(.DATA_WIDTH(64), .ADDR_WIDTH(9), .SEG_WIDTH(29), .INIT_EN(0)) dut_b (
    .CLK(clk), .RST(rst_b), .CEN(cen_b), .A(a_b), .GWEN(gwen_b),
    .WEN(wen_b), .D(d_b), .Q(q_b), .BUSY(busy_b)
  );

  int checks = 0;
  int errors = 0;

  // word-level model, one per instance
  logic [63:0] mem   [2][512];
  bit          known [2][512];
  logic [63:0] mq    [2];
  bit          mqk   [2];
  int          init_left [2];
  bit          pend  [2];
  logic [8:0]  pa    [2];
  logic [63:0] pd    [2];
  logic [63:0] pw    [2];
  bit          started [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input logic rst, input logic cen,
                            input logic [8:0] a, input logic gwen,
                            input logic [63:0] wen, input logic [63:0] d);
    logic [63:0] mask;
    logic [63:0] w;
    mask = (k == 0) ? {5'b0, {59{1'b1}}} : {64{1'b1}};
    w = wen & mask;
    if (rst) begin
      started[k]   = 1;
      pend[k]      = 0;
      mq[k]        = '0;
      mqk[k]       = 1;
      init_left[k] = (k == 0) ? 512 : 0;
    end else if (!started[k]) begin
      // before the first reset nothing is defined
    end else if (init_left[k] > 0) begin
      mem[k][512 - init_left[k]]   = '0;
      known[k][512 - init_left[k]] = 1;
      init_left[k]--;
    end else if (pend[k]) begin
      mem[k][pa[k]] = ((pd[k] & ~pw[k]) | (mem[k][pa[k]] & pw[k])) & mask;
      mq[k]  = mem[k][pa[k]];
      mqk[k] = known[k][pa[k]];
      pend[k] = 0;
    end else if (!cen) begin
      if (gwen || w == mask) begin
        mq[k]  = mem[k][a];
        mqk[k] = known[k][a];
      end else if (w == '0) begin
        mem[k][a]   = d & mask;
        known[k][a] = 1;
        mq[k]  = d & mask;
        mqk[k] = 1;
      end else begin
        pend[k] = 1;
        pa[k] = a;
        pd[k] = d & mask;
        pw[k] = w;
      end
    end
  endtask

  task automatic compare(input int k);
    if (started[k]) begin
      if (k == 0) begin
        chk("busy_a", {63'b0, busy_a}, {63'b0, (init_left[0] > 0 || pend[0])});
        if (mqk[0]) chk("q_a", {5'b0, q_a}, mq[0]);
      end else begin
        chk("busy_b", {63'b0, busy_b}, {63'b0, (init_left[1] > 0 || pend[1])});
        if (mqk[1]) chk("q_b", q_b, mq[1]);
      end
    end
  endtask

  task automatic cycle();
    model_step(0, rst_a, cen_a, a_a, gwen_a, {5'b0, wen_a}, {5'b0, d_a});
    model_step(1, rst_b, cen_b, a_b, gwen_b, wen_b, d_b);
    @(posedge clk);
    #1;
    compare(0);
    compare(1);
  endtask

  task automatic drv_a(input logic cen, input logic [8:0] a, input logic gwen,
                       input logic [63:0] wen, input logic [63:0] d);
    cen_a = cen; a_a = a; gwen_a = gwen; wen_a = wen[58:0]; d_a = d[58:0];
  endtask

  task automatic drv_b(input logic cen, input logic [8:0] a, input logic gwen,
                       input logic [63:0] wen, input logic [63:0] d);
    cen_b = cen; a_b = a; gwen_b = gwen; wen_b = wen; d_b = d;
  endtask

  task automatic rnd_op(output logic cen, output logic [8:0] a, output logic gwen,
                        output logic [63:0] wen, output logic [63:0] d);
    int kind;
    cen  = ($urandom_range(0, 3) == 0);
    a    = 9'($urandom_range(0, 15));
    gwen = ($urandom_range(0, 2) == 0);
    d    = {$urandom, $urandom};
    kind = $urandom_range(0, 3);
    case (kind)
      0: wen = '0;
      1: wen = '1;
      2: wen = {$urandom, $urandom};
      default: wen = ~(64'd1 << $urandom_range(0, 63));
    endcase
  endtask

  int n;
  logic        rc, rg;
  logic [8:0]  ra;
  logic [63:0] rw, rd;

  initial begin
    drv_a(1'b1, '0, 1'b1, '1, '0);
    drv_b(1'b1, '0, 1'b1, '1, '0);
    rst_a = 1'b1; rst_b = 1'b1;
    #1;
    cycle(); cycle();
    chk("rst_q_a", {5'b0, q_a}, 64'd0);
    chk("rst_busy_a", {63'b0, busy_a}, 64'd1);
    chk("rst_busy_b", {63'b0, busy_b}, 64'd0);
    rst_a = 1'b0; rst_b = 1'b0;

    // clear sequence duration
    n = 0;
    while (busy_a && n < 600) begin cycle(); n++; end
    chk("init_len", 64'(n), 64'd512);

    drv_a(1'b0, 9'd0, 1'b1, '1, '0);   cycle(); chk("init_rd0", {5'b0, q_a}, 64'd0);
    drv_a(1'b0, 9'd255, 1'b1, '1, '0); cycle(); chk("init_rd255", {5'b0, q_a}, 64'd0);
    drv_a(1'b0, 9'd511, 1'b1, '1, '0); cycle(); chk("init_rd511", {5'b0, q_a}, 64'd0);

    // full write then read
    drv_a(1'b0, 9'h1F0, 1'b0, '0, 64'h05A5A5A5A5A5A5A5); cycle();
    chk("fw_q", {5'b0, q_a}, 64'h05A5A5A5A5A5A5A5);
    drv_a(1'b0, 9'h1F0, 1'b1, '1, '0); cycle();
    chk("fw_rd", {5'b0, q_a}, 64'h05A5A5A5A5A5A5A5);

    // partial write over all-ones word, low slice cleared
    drv_a(1'b0, 9'd3, 1'b0, '0, '1); cycle();
    drv_a(1'b0, 9'd3, 1'b0, {35'h7FFFFFFFF, 29'h0}, '0); cycle();
    drv_a(1'b1, 9'd0, 1'b1, '1, '0);
    chk("pw_busy1", {63'b0, busy_a}, 64'd1);
    cycle();
    chk("pw_busy0", {63'b0, busy_a}, 64'd0);
    chk("pw_q", {5'b0, q_a}, {5'b0, 30'h3FFFFFFF, 29'h0});
    drv_a(1'b0, 9'd3, 1'b1, '1, '0); cycle();
    chk("pw_rd", {5'b0, q_a}, {5'b0, 30'h3FFFFFFF, 29'h0});

    // access during the RMW cycle is ignored
    drv_a(1'b0, 9'd4, 1'b0, '0, 64'h123); cycle();
    drv_a(1'b0, 9'd5, 1'b0, 64'hFF, 64'h0); cycle();
    drv_a(1'b0, 9'd4, 1'b0, '0, 64'h777); cycle();
    drv_a(1'b0, 9'd4, 1'b1, '1, '0); cycle();
    chk("busy_ign", {5'b0, q_a}, 64'h123);

    // reset in the RMW cycle restarts the clear
    drv_a(1'b0, 9'd6, 1'b0, 64'hF0, 64'h0); cycle();
    drv_a(1'b1, 9'd0, 1'b1, '1, '0);
    rst_a = 1'b1; cycle(); rst_a = 1'b0;
    chk("rmw_rst_q", {5'b0, q_a}, 64'd0);
    n = 0;
    while (busy_a && n < 600) begin cycle(); n++; end
    chk("reinit_len", 64'(n), 64'd512);

    // random traffic on A
    for (int i = 0; i < 250; i++) begin
      rnd_op(rc, ra, rg, rw, rd);
      drv_a(rc, ra, rg, rw, rd);
      cycle();
    end
    drv_a(1'b1, '0, 1'b1, '1, '0);
    cycle();

    // instance B: merge across slice boundaries
    drv_b(1'b0, 9'd7, 1'b0, '0, '1); cycle();
    drv_b(1'b0, 9'd7, 1'b0, 64'h5555555555555555, 64'h0123456789ABCDEF); cycle();
    drv_b(1'b1, '0, 1'b1, '1, '0); cycle();
    chk("b_merge_q", q_b, 64'h55775577DDFFDDFF);
    drv_b(1'b0, 9'd7, 1'b1, '1, '0); cycle();
    chk("b_merge_rd", q_b, 64'h55775577DDFFDDFF);

    // reset during RMW keeps the old word
    drv_b(1'b0, 9'd8, 1'b0, '0, 64'hDEAD); cycle();
    drv_b(1'b0, 9'd8, 1'b0, 64'hFFFFFFFFFFFF0000, 64'h0); cycle();
    drv_b(1'b1, '0, 1'b1, '1, '0);
    rst_b = 1'b1; cycle(); rst_b = 1'b0;
    chk("b_rst_q", q_b, 64'd0);
    drv_b(1'b0, 9'd8, 1'b1, '1, '0); cycle();
    chk("b_rst_keep", q_b, 64'hDEAD);

    // random traffic on B with occasional reset
    for (int i = 0; i < 400; i++) begin
      rnd_op(rc, ra, rg, rw, rd);
      drv_b(rc, ra, rg, rw, rd);
      rst_b = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst_b = 1'b0;
    drv_b(1'b1, '0, 1'b1, '1, '0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
